// File: rtl/muxn_reg_if.sv
// Bundle of data, select-request and output signals between muxn_reg and its environment.
// Ports: master drives d/sel_in/sel_load and observes sel_cur/sel_busy/sel_err/z/z_valid;
//        slave (the mux) is the mirror image. SELW = max(1, clog2(NCH)).
interface muxn_reg_if #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4
);
    localparam int SELW = (NCH > 2) ? $clog2(NCH) : 1;

    logic [NCH*WIDTH-1:0] d;
    logic [SELW-1:0]      sel_in;
    logic                 sel_load;
    logic [SELW-1:0]      sel_cur;
    logic                 sel_busy;
    logic                 sel_err;
    logic [WIDTH-1:0]     z;
    logic                 z_valid;

    modport master (
        output d, sel_in, sel_load,
        input  sel_cur, sel_busy, sel_err, z, z_valid
    );

    modport slave (
        input  d, sel_in, sel_load,
        output sel_cur, sel_busy, sel_err, z, z_valid
    );
endinterface

// File: rtl/muxn_reg.sv
// NCH-channel WIDTH-bit mux with registered output and break-before-make select switching.
// Latency: d to z is 1 cycle; an accepted switch blanks z_valid for 1+SETTLE_CYC cycles.
// Backpressure: requests are ignored while sel_busy is high; out-of-range requests pulse sel_err.
// Ports: clk, rst (async, active-high), bus (muxn_reg_if.slave: d, sel_in, sel_load,
//        sel_cur, sel_busy, sel_err, z, z_valid).
// Option: define MUXN_HOLD_LAST_EN to hold the last RUN value on z during the blank window
//         instead of forcing it to zero.
module muxn_reg #(
    parameter int WIDTH      = 8,
    parameter int NCH        = 4,
    parameter int SETTLE_CYC = 2,
    parameter int RST_SEL    = 0
) (
    input  logic        clk,
    input  logic        rst,
    muxn_reg_if.slave   bus
);
    localparam int SELW = (NCH > 2) ? $clog2(NCH) : 1;

    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] BLANK  = 2'd1;
    localparam logic [1:0] SETTLE = 2'd2;

    // One extra bit so the range check works even when NCH is a power of two.
    localparam logic [SELW:0]   NCH_W     = (SELW+1)'(NCH);
    localparam logic [SELW-1:0] RST_SEL_W = SELW'(RST_SEL);
    localparam logic [7:0]      SETTLE_W  = 8'(SETTLE_CYC);

    logic [1:0]       state;
    logic [SELW-1:0]  sel_cur_q;
    logic [SELW-1:0]  pending;
    logic [7:0]       cnt;
    logic [WIDTH-1:0] z_q;
    logic             z_valid_q;
    logic             err_q;

    logic [WIDTH-1:0] cur_dat;
    logic [WIDTH-1:0] pend_dat;
    logic [WIDTH-1:0] blank_dat;
    logic             req_oor;
    logic             req_switch;

    // One-hot style decode: exactly one channel can match, so z is never a blend.
    always_comb begin
        cur_dat  = '0;
        pend_dat = '0;
        for (int i = 0; i < NCH; i++) begin
            if (sel_cur_q == SELW'(i)) cur_dat  = bus.d[i*WIDTH +: WIDTH];
            if (pending   == SELW'(i)) pend_dat = bus.d[i*WIDTH +: WIDTH];
        end
    end

`ifdef MUXN_HOLD_LAST_EN
    assign blank_dat = z_q;
`else
    assign blank_dat = '0;
`endif

    assign req_oor    = bus.sel_load && ({1'b0, bus.sel_in} >= NCH_W);
    assign req_switch = bus.sel_load && !req_oor && (bus.sel_in != sel_cur_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            sel_cur_q <= RST_SEL_W;
            pending   <= RST_SEL_W;
            cnt       <= 8'd0;
            z_q       <= '0;
            z_valid_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                RUN: begin
                    if (req_switch) begin
                        pending   <= bus.sel_in;
                        state     <= BLANK;
                        z_q       <= blank_dat;
                        z_valid_q <= 1'b0;
                    end else begin
                        // Same-channel and out-of-range requests leave the data path running.
                        err_q     <= req_oor;
                        z_q       <= cur_dat;
                        z_valid_q <= 1'b1;
                    end
                end
                BLANK: begin
                    sel_cur_q <= pending;
                    cnt       <= SETTLE_W;
                    if (SETTLE_CYC == 0) begin
                        // Old sel_cur is still registered here, so route from pending.
                        state     <= RUN;
                        z_q       <= pend_dat;
                        z_valid_q <= 1'b1;
                    end else begin
                        state     <= SETTLE;
                        z_q       <= blank_dat;
                        z_valid_q <= 1'b0;
                    end
                end
                SETTLE: begin
                    cnt <= cnt - 8'd1;
                    if (cnt <= 8'd1) begin
                        state     <= RUN;
                        z_q       <= cur_dat;
                        z_valid_q <= 1'b1;
                    end else begin
                        z_q       <= blank_dat;
                        z_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state     <= RUN;
                    z_q       <= '0;
                    z_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sel_cur  = sel_cur_q;
    assign bus.sel_busy = (state != RUN);
    assign bus.sel_err  = err_q;
    assign bus.z        = z_q;
    assign bus.z_valid  = z_valid_q;
endmodule

// File: tb/tb_muxn_reg.sv
// Directed bench for muxn_reg: three instances (settle=2, settle=0 with RST_SEL=2, NCH=3).
// Expected output tuples are queued per step and compared after the next clock edge.
module tb_muxn_reg;
    logic clk;
    logic rst;

    muxn_reg_if #(.WIDTH(8), .NCH(4)) ifa ();
    muxn_reg_if #(.WIDTH(8), .NCH(4)) ifb ();
    muxn_reg_if #(.WIDTH(8), .NCH(3)) ifc ();

    muxn_reg #(.WIDTH(8), .NCH(4), .SETTLE_CYC(2), .RST_SEL(0)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    muxn_reg #(.WIDTH(8), .NCH(4), .SETTLE_CYC(0), .RST_SEL(2)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
    muxn_reg #(.WIDTH(8), .NCH(3), .SETTLE_CYC(1), .RST_SEL(0)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

`ifdef MUXN_HOLD_LAST_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    typedef struct {
        string      tag;
        int         dut;
        logic [7:0] z;
        logic       v;
        logic       busy;
        logic       err;
        logic [1:0] cur;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] bl(input logic [7:0] held);
        return HOLD ? held : 8'h00;
    endfunction

    task automatic ex(input int dut, input string tag, input logic [7:0] z, input logic v,
                      input logic busy, input logic err, input logic [1:0] cur);
        exp_t e;
        e.tag = tag; e.dut = dut; e.z = z; e.v = v; e.busy = busy; e.err = err; e.cur = cur;
        q.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        logic [12:0] obs;
        logic [12:0] want;
        while (q.size() > 0) begin
            e = q.pop_front();
            case (e.dut)
                0:       obs = {ifa.z, ifa.z_valid, ifa.sel_busy, ifa.sel_err, ifa.sel_cur};
                1:       obs = {ifb.z, ifb.z_valid, ifb.sel_busy, ifb.sel_err, ifb.sel_cur};
                default: obs = {ifc.z, ifc.z_valid, ifc.sel_busy, ifc.sel_err, ifc.sel_cur};
            endcase
            want = {e.z, e.v, e.busy, e.err, e.cur};
            total++;
            assert (obs === want) else begin
                bad++;
                $error("FAIL %s: observed {z,v,busy,err,cur}=%h expected=%h", e.tag, obs, want);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check();
    endtask

    initial begin
        rst = 1'b1;
        ifa.d = {8'h33, 8'h44, 8'h22, 8'h11}; ifa.sel_in = 2'd0; ifa.sel_load = 1'b0;
        ifb.d = {8'hA3, 8'hA2, 8'hA1, 8'hA0}; ifb.sel_in = 2'd0; ifb.sel_load = 1'b0;
        ifc.d = {8'hC2, 8'hC1, 8'hC0};        ifc.sel_in = 2'd0; ifc.sel_load = 1'b0;

        // Reset state, before and at the first edge.
        #1;
        ex(0, "rst_a", 8'h00, 0, 0, 0, 2'd0);
        ex(1, "rst_b", 8'h00, 0, 0, 0, 2'd2);
        ex(2, "rst_c", 8'h00, 0, 0, 0, 2'd0);
        check();
        ex(0, "rst_edge_a", 8'h00, 0, 0, 0, 2'd0);
        ex(1, "rst_edge_b", 8'h00, 0, 0, 0, 2'd2);
        tick();
        rst = 1'b0;

        // First edge after release already valid.
        ex(0, "first_a", 8'h11, 1, 0, 0, 2'd0);
        ex(1, "first_b", 8'hA2, 1, 0, 0, 2'd2);
        ex(2, "first_c", 8'hC0, 1, 0, 0, 2'd0);
        tick();

        // Continuous update and same-channel request.
        ifa.d[7:0] = 8'h12;
        ex(0, "upd_a", 8'h12, 1, 0, 0, 2'd0);
        tick();
        ifa.d[7:0] = 8'h11;
        ex(0, "upd_back_a", 8'h11, 1, 0, 0, 2'd0);
        tick();
        ifa.sel_in = 2'd0; ifa.sel_load = 1'b1;
        ex(0, "same_sel_a", 8'h11, 1, 0, 0, 2'd0);
        tick();

        // Switch 0 -> 3 with two settle cycles.
        ifa.sel_in = 2'd3;
        ex(0, "sw_k_a", bl(8'h11), 0, 1, 0, 2'd0);
        tick();
        ifa.sel_load = 1'b0;
        ifa.d[7:0] = 8'h5A;
        ex(0, "sw_k1_a", bl(8'h11), 0, 1, 0, 2'd3);
        tick();
        ifa.sel_in = 2'd1; ifa.sel_load = 1'b1;
        ex(0, "sw_k2_busy_a", bl(8'h11), 0, 1, 0, 2'd3);
        tick();
        ifa.sel_load = 1'b0;
        ex(0, "sw_k3_a", 8'h33, 1, 0, 0, 2'd3);
        tick();
        ex(0, "sw_steady_a", 8'h33, 1, 0, 0, 2'd3);
        tick();

        // Reset in the middle of a switch to channel 1.
        ifa.sel_in = 2'd1; ifa.sel_load = 1'b1;
        ex(0, "sw2_k_a", bl(8'h33), 0, 1, 0, 2'd3);
        tick();
        ifa.sel_load = 1'b0;
        ex(0, "sw2_k1_a", bl(8'h33), 0, 1, 0, 2'd1);
        tick();
        #2 rst = 1'b1;
        #1;
        ex(0, "mid_rst_a", 8'h00, 0, 0, 0, 2'd0);
        check();
        #1 rst = 1'b0;
        ex(0, "post_rst_a", 8'h5A, 1, 0, 0, 2'd0);
        ex(1, "post_rst_b", 8'hA2, 1, 0, 0, 2'd2);
        ex(2, "post_rst_c", 8'hC0, 1, 0, 0, 2'd0);
        tick();
        ex(0, "post_rst2_a", 8'h5A, 1, 0, 0, 2'd0);
        tick();

        // Zero settle: exactly one blank cycle.
        ifb.sel_in = 2'd1; ifb.sel_load = 1'b1;
        ex(1, "z0_k_b", bl(8'hA2), 0, 1, 0, 2'd2);
        tick();
        ifb.sel_load = 1'b0;
        ex(1, "z0_k1_b", 8'hA1, 1, 0, 0, 2'd1);
        tick();
        ifb.d[15:8] = 8'hB1;
        ex(1, "z0_upd_b", 8'hB1, 1, 0, 0, 2'd1);
        tick();

        // Out-of-range request on a 3-channel mux.
        ifc.sel_in = 2'd3; ifc.sel_load = 1'b1;
        ex(2, "oor_c", 8'hC0, 1, 0, 1, 2'd0);
        tick();
        ifc.sel_load = 1'b0;
        ex(2, "oor_end_c", 8'hC0, 1, 0, 0, 2'd0);
        tick();

        // Switch 0 -> 2 with one settle cycle; out-of-range while busy is silent.
        ifc.sel_in = 2'd2; ifc.sel_load = 1'b1;
        ex(2, "sw_k_c", bl(8'hC0), 0, 1, 0, 2'd0);
        tick();
        ifc.sel_in = 2'd3;
        ex(2, "sw_k1_c", bl(8'hC0), 0, 1, 0, 2'd2);
        tick();
        ifc.sel_load = 1'b0;
        ex(2, "sw_k2_c", 8'hC2, 1, 0, 0, 2'd2);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
